// File: rtl/tim_pkg.sv
// rtl/tim_pkg.sv - shared timer types and defaults for tim and tim_capture
package tim_pkg;

  localparam int TIM_WIDTH       = 16;
  localparam int TIM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } tim_cap_state_t;

endpackage

// File: rtl/tim_cap_sync.sv
// rtl/tim_cap_sync.sv - input synchronizer, optional glitch filter, edge detector
// Glitch filter is built only when TIM_CAP_FILTER_EN is defined.
module tim_cap_sync
  import tim_pkg::*;
#(
  parameter int SYNC_STAGES = TIM_SYNC_STAGES,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall,
  output logic level
);

`ifdef TIM_CAP_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   s;
  logic                   d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (FILT_ON && FILTER_LEN >= 1) begin : g_filt
    localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(FILTER_LEN - 1);

    logic [RW-1:0] run_q;
    logic          filt_q;

    // Output follows the input only once it has disagreed for FILTER_LEN samples in a row.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        run_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync_out == filt_q) begin
        run_q <= '0;
      end else if (run_q == RUN_LAST) begin
        run_q  <= '0;
        filt_q <= sync_out;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end

    assign s = filt_q;
  end else begin : g_nofilt
    assign s = sync_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d <= 1'b0;
    end else begin
      d <= s;
    end
  end

  assign rise  = s & ~d;
  assign fall  = ~s & d;
  assign level = s;

endmodule

// File: rtl/tim_capture.sv
// rtl/tim_capture.sv - PWM input capture: period and high time in prescaled ticks
// Optional input glitch filter selected by TIM_CAP_FILTER_EN.
module tim_capture
  import tim_pkg::*;
#(
  parameter int WIDTH       = TIM_WIDTH,
  parameter int SYNC_STAGES = TIM_SYNC_STAGES,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] prescaler,
  input  logic             in_pwm,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] pulse,
  output logic             valid,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  tim_cap_state_t state, state_nxt;

  logic             rise;
  logic             fall;
  logic             level_unused;
  logic             tick;
  logic [WIDTH-1:0] div, div_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] pulse_shadow, shadow_nxt;
  logic [WIDTH-1:0] period_nxt, pulse_nxt;
  logic             valid_nxt;
  logic             ovf_set;
  logic             overflow_nxt;

  tim_cap_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .in   (in_pwm),
    .rise (rise),
    .fall (fall),
    .level(level_unused)
  );

  // >= rather than == so that lowering prescaler below div cannot stall the tick.
  assign tick    = (div >= prescaler);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + WIDTH'(tick);

  always_comb begin
    state_nxt  = state;
    div_nxt    = tick ? '0 : div + 1'b1;
    cnt_nxt    = cnt_inc;
    shadow_nxt = pulse_shadow;
    period_nxt = period;
    pulse_nxt  = pulse;
    valid_nxt  = 1'b0;
    ovf_set    = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      div_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          div_nxt   = '0;
          cnt_nxt   = '0;
        end
        ARM: begin
          div_nxt = '0;
          cnt_nxt = '0;
          if (rise) begin
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (cnt_inc == CNT_MAX) begin
            ovf_set   = 1'b1;
            state_nxt = ARM;
            div_nxt   = '0;
            cnt_nxt   = '0;
          end else if (fall) begin
            shadow_nxt = cnt_inc;
            state_nxt  = LOW;
          end
        end
        LOW: begin
          if (cnt_inc == CNT_MAX) begin
            ovf_set   = 1'b1;
            state_nxt = ARM;
            div_nxt   = '0;
            cnt_nxt   = '0;
          end else if (rise) begin
            period_nxt = cnt_inc;
            pulse_nxt  = pulse_shadow;
            valid_nxt  = 1'b1;
            div_nxt    = '0;
            cnt_nxt    = '0;
            state_nxt  = HIGH;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // A saturation in the same cycle as a clear must not be lost.
    overflow_nxt = ovf_set | (overflow & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      div          <= '0;
      cnt          <= '0;
      pulse_shadow <= '0;
      period       <= '0;
      pulse        <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      div          <= div_nxt;
      cnt          <= cnt_nxt;
      pulse_shadow <= shadow_nxt;
      period       <= period_nxt;
      pulse        <= pulse_nxt;
      valid        <= valid_nxt;
      overflow     <= overflow_nxt;
    end
  end

endmodule

// File: doc/tim_capture.md
Name: tim_capture

Overview:
PWM input-capture block, the receive-side counterpart of the tim PWM generator.
- Measures period and high time of an external PWM signal in prescaled ticks, using the same prescaler semantics as tim.
- Reports each completed cycle with a one-clock valid strobe.
- Flags counter saturation (0%/100% duty, lost signal) with a sticky overflow bit.
- Sits in the timer peripheral next to tim, feeding the bus register file.

Parameters:
WIDTH, 16, width of the tick counter, prescaler and captured values
SYNC_STAGES, 2, input synchronizer depth (>=2)
FILTER_LEN, 3, stable-sample count for the glitch filter (used only with TIM_CAP_FILTER_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
enable  input  1  capture enable
prescaler  input  WIDTH  tick every prescaler+1 clk cycles
in_pwm  input  1  asynchronous PWM input
ovf_clr  input  1  clears the overflow flag
period  output  WIDTH  last captured period, in ticks
pulse  output  WIDTH  last captured high time, in ticks
valid  output  1  one-cycle strobe when period/pulse are updated
overflow  output  1  sticky saturation flag

Behaviour:
- Reset (rst=0, async): state IDLE, div=0, cnt=0, period=0, pulse=0, valid=0, overflow=0.
- Input path:
  - in_pwm passes through SYNC_STAGES flops, then one delay flop.
  - rise = s & ~d; fall = ~s & d.
  - An input edge is acted on SYNC_STAGES+1 clk cycles after it occurs.
- Prescaler:
  - tick = (div >= prescaler). On a tick div <= 0, otherwise div <= div+1.
  - prescaler=0 gives a tick every cycle.
  - A prescaler change takes effect immediately; the >= compare prevents a lockout.
- Counter: cnt_next = cnt + tick, saturating at 2^WIDTH-1.
- States:
  - IDLE: enable=0. div and cnt are held at 0; period/pulse hold their values; valid=0. enable=1 -> ARM.
  - ARM: waits for rise; a fall is ignored. On rise: cnt<=0, div<=0 -> HIGH.
  - HIGH: counts. On fall: pulse_shadow<=cnt_next -> LOW.
  - LOW: counts. On rise: period<=cnt_next, pulse<=pulse_shadow, valid<=1 for one cycle, cnt<=0, div<=0 -> HIGH.
- Capture latency: period/pulse/valid update on the clk edge following the cycle in which rise is detected.
- Saturation:
  - If cnt_next == 2^WIDTH-1 in HIGH or LOW: overflow<=1 -> ARM, no capture.
  - The next rise restarts a measurement without producing valid.
- overflow is cleared by ovf_clr. If a set and a clear occur in the same cycle, the set wins.
- enable deasserted in any state -> IDLE next cycle. A partial measurement is discarded and valid is not asserted.
- Reset asserted mid-measurement: all state and outputs return to reset values immediately.
- valid never asserts on two consecutive cycles. Each capture needs at least 2 edges, so the minimum capture spacing is 2 cycles.

Optional Feature:
TIM_CAP_FILTER_EN
- Defined: the synchronized input feeds a glitch filter. Its output changes only after FILTER_LEN consecutive equal samples. Edge latency becomes SYNC_STAGES+FILTER_LEN+1. Pulses shorter than FILTER_LEN clocks are suppressed.
- Undefined: no filter; latency is SYNC_STAGES+1 and every synchronized transition is an edge.

Decomposition:
- tim_pkg holds the tim_cap_state_t enum (IDLE, ARM, HIGH, LOW), the TIM_WIDTH default and the synchronizer depth default, shared with tim.
- One sub-module, tim_cap_sync: synchronizer, optional filter and rise/fall detector. Inputs clk, rst, in; outputs rise, fall, level.
- The FSM, prescaler and counter stay in tim_capture.

Test Plan:
- prescaler=0, in_pwm period 10 clk, high 5 clk, enable=1 -> valid once per 10 clk, starting from the second rise; period=10, pulse=5.
- prescaler=2, in_pwm period 30 clk, high 15 clk -> period=10, pulse=5. Then loop tim (counter_period=10, pulse=5, prescaler=2) out_p_1 into in_pwm and check the values are consistent every cycle.
- WIDTH=8, prescaler=0, in_pwm held high after a rise -> overflow=1 after 255 clk, state ARM, no valid. Then pulse ovf_clr -> overflow=0, and ovf_clr coincident with a new saturation -> overflow stays 1.
- Deassert enable mid-HIGH, reassert 20 clk later -> no valid from the broken cycle. The first valid comes only after ARM, rise, fall, rise; period/pulse keep their old values until then.
- Assert rst for 3 clk mid-LOW -> period=pulse=0, valid=0, overflow=0 asynchronously; capture resumes normally after release.
- With TIM_CAP_FILTER_EN and FILTER_LEN=3, inject a 2-clk glitch low during a high phase -> no fall registered and pulse unchanged; a 3-clk low is accepted.
